// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream multiplexer with round-robin or forced-select
// arbitration feeding a one-entry registered output stage.
module rr_stream_mux #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_ch_q, out_ch_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;

  logic                can_load;
  logic [NUM_CH-1:0]   rr_mask;
  logic [NUM_CH-1:0]   rr_masked;
  logic [NUM_CH-1:0]   rr_pick;
  logic                grant_valid;
  logic [SEL_W-1:0]    grant_idx;

  // Round-robin: requests at or above the pointer win first; if none, the
  // unmasked vector supplies the wrap-around winner. Lowest set bit wins.
  always_comb begin
    can_load    = (state_q == EMPTY) || out_ready;
    rr_mask     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rr_mask[i] = (i >= int'(ptr_q));
    end
    rr_masked   = in_valid & rr_mask;
    rr_pick     = (|rr_masked) ? rr_masked : in_valid;
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (rst_n && can_load) begin
      if (!mode) begin
        grant_valid = |rr_pick;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (rr_pick[i]) grant_idx = SEL_W'(i);
        end
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (sel == SEL_W'(i) && in_valid[i]) begin
            grant_valid = 1'b1;
            grant_idx   = SEL_W'(i);
          end
        end
      end
    end
    in_ready = grant_valid ? (NUM_CH'(1) << grant_idx) : '0;
  end

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    ptr_d      = ptr_q;
    if (grant_valid) begin
      state_d    = FULL;
      out_data_d = in_data[int'(grant_idx)*DATA_W +: DATA_W];
      out_ch_d   = grant_idx;
      if (!mode) begin
        ptr_d = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      end
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_ch_q   <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      ptr_q      <= ptr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Scoreboard bench for rr_stream_mux: a queue-based reference model predicts
// each grant, and a separate monitor checks every word the DUT presents.
module tb_rr_stream_mux;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mode = 1'b0;
  logic [SEL_W-1:0]  sel = '0;
  logic [NUM_CH-1:0] in_valid = '0;
  logic [NUM_CH-1:0] in_ready;
  logic [31:0]       in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [SEL_W-1:0]  out_ch;

  logic [2:0]        in_ready3;
  logic              out_valid3;
  logic [DATA_W-1:0] out_data3;
  logic [SEL_W-1:0]  out_ch3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                ch;
  } word_t;

  word_t exp_q[$];
  int    model_ptr = 0;
  bit    started   = 0;
  bit    zeroed    = 0;

  always #5 clk = ~clk;

  rr_stream_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch)
  );

  // Three-channel instance: sel=3 addresses a channel that does not exist.
  rr_stream_mux #(.NUM_CH(3), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(1'b1), .sel(2'd3),
    .in_valid(in_valid[2:0]), .in_ready(in_ready3), .in_data(in_data[23:0]),
    .out_valid(out_valid3), .out_ready(out_ready),
    .out_data(out_data3), .out_ch(out_ch3)
  );

  function automatic void compare(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Channel the reference model expects to be granted this cycle, or -1.
  function automatic int modelGrant();
    bit can_load;
    can_load = (exp_q.size() == 0) || out_ready;
    if (!rst_n || !can_load) return -1;
    if (mode) return (int'(sel) < NUM_CH && in_valid[sel]) ? int'(sel) : -1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (in_valid[(model_ptr + k) % NUM_CH]) return (model_ptr + k) % NUM_CH;
    end
    return -1;
  endfunction

  // Monitor: every presented word is compared with the scoreboard head.
  always @(negedge clk) begin
    if (started) begin
      compare("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        compare("out_data", out_data, exp_q[0].data);
        compare("out_ch", out_ch, exp_q[0].ch);
        if (out_ready) void'(exp_q.pop_front());
      end else if (zeroed) begin
        compare("out_data_reset", out_data, 0);
        compare("out_ch_reset", out_ch, 0);
      end
      compare("in_ready_nch3", in_ready3, 0);
      compare("out_valid_nch3", out_valid3, 0);
    end
  end

  task automatic checkOutput(output int g);
    int exp_ready;
    g = modelGrant();
    exp_ready = (g >= 0) ? (1 << g) : 0;
    compare("in_ready", in_ready, exp_ready);
  endtask

  task automatic applyStimulus(input logic r, input logic md, input logic [1:0] s,
                               input logic [3:0] v, input logic rdy,
                               input logic [31:0] d);
    int g;
    word_t w;
    rst_n = r; mode = md; sel = s; in_valid = v; out_ready = rdy; in_data = d;
    @(negedge clk);
    #1;
    checkOutput(g);
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      model_ptr = 0;
      zeroed    = 1;
      started   = 1;
    end else if (g >= 0) begin
      w.data = DATA_W'(d >> (8 * g));
      w.ch   = g;
      exp_q.push_back(w);
      zeroed = 0;
      if (!mode) model_ptr = (g + 1) % NUM_CH;
    end
    #1;
  endtask

  initial begin
    logic [31:0] fixed;
    fixed = 32'h43322110;
    @(posedge clk);
    #1;

    // Reset with every channel requesting.
    repeat (2) applyStimulus(1'b0, 1'b0, 2'd0, 4'hF, 1'b1, fixed);

    // Round-robin over all four channels, then over channels 1 and 3.
    repeat (8) applyStimulus(1'b1, 1'b0, 2'd0, 4'hF, 1'b1, fixed);
    repeat (6) applyStimulus(1'b1, 1'b0, 2'd0, 4'hA, 1'b1, $urandom);

    // Backpressure on a word from channel 2, then release with requests pending.
    applyStimulus(1'b1, 1'b1, 2'd2, 4'h4, 1'b1, 32'h00550000);
    repeat (5) applyStimulus(1'b1, 1'b0, 2'd0, 4'hF, 1'b0, $urandom);
    repeat (3) applyStimulus(1'b1, 1'b0, 2'd0, 4'hF, 1'b1, $urandom);

    // Forced select: channel 2, then an idle channel 3.
    repeat (4) applyStimulus(1'b1, 1'b1, 2'd2, 4'hF, 1'b1, $urandom);
    repeat (3) applyStimulus(1'b1, 1'b1, 2'd3, 4'h7, 1'b1, $urandom);

    // Reset while holding 0x43 from channel 3.
    applyStimulus(1'b1, 1'b1, 2'd3, 4'h8, 1'b0, fixed);
    applyStimulus(1'b1, 1'b1, 2'd3, 4'h8, 1'b0, fixed);
    applyStimulus(1'b0, 1'b0, 2'd0, 4'hF, 1'b0, fixed);
    repeat (3) applyStimulus(1'b1, 1'b0, 2'd0, 4'hE, 1'b1, fixed);

    // Random traffic with occasional resets and mode/sel changes.
    repeat (400) begin
      applyStimulus(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 4'($urandom),
                    ($urandom_range(0, 3) != 0), $urandom);
    end

    repeat (2) applyStimulus(1'b1, 1'b0, 2'd0, 4'h0, 1'b1, $urandom);
    compare("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N-channel stream multiplexer, the successor to the fixed 2-bit-select 4:1 mux.
- Selects one of NUM_CH valid/ready input streams and forwards its word through a one-entry registered output stage.
- Two modes:
  - round-robin arbitration across all requesting channels;
  - forced select, where the external sel input chooses the channel (classic mux behaviour plus handshake).
- Sits between multiple producers and a single consumer in the datapath.

Parameters:
- NUM_CH, 4, number of input channels (>=2).
- DATA_W, 8, width of each data word.
- SEL_W, 2, width of sel and out_ch; must satisfy 2**SEL_W >= NUM_CH.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- mode  input  1  0 = round-robin, 1 = forced select.
- sel  input  SEL_W  channel index used when mode=1.
- in_valid  input  NUM_CH  per-channel valid; bit i belongs to channel i.
- in_ready  output  NUM_CH  per-channel ready (one-hot or zero).
- in_data  input  NUM_CH*DATA_W  flattened data; channel i occupies bits [i*DATA_W +: DATA_W].
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  DATA_W  registered data.
- out_ch  output  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Reset is synchronous (rst_n low at a rising edge): out_valid=0, out_data=0, out_ch=0, RR pointer=0 (channel 0 highest priority). in_ready is combinational and forced to 0 while rst_n=0. Reset mid-transfer drops the held word with no output handshake.
- Output stage states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- can_load = !out_valid || out_ready.
- Arbitration is combinational each cycle, and only when can_load=1:
  - mode=0: grant the first channel with in_valid=1, searching from ptr, ptr+1, ... wrapping at NUM_CH-1 -> 0.
  - mode=1: grant channel sel iff sel < NUM_CH and in_valid[sel]=1. If sel >= NUM_CH, there is no grant.
- in_ready[g]=1 only for the granted channel g; all other bits are 0. in_ready depends on in_valid. Producers must not wait for ready before asserting valid.
- Transfer on input i: in_valid[i] && in_ready[i] at the rising edge. Next cycle: out_data = channel i data, out_ch = i, out_valid = 1.
- Latency is 1 cycle, input handshake to out_valid.
- Throughput is 1 word/cycle when out_ready is held high.
- Output handshake (out_valid && out_ready) with no new grant in the same cycle -> out_valid=0. A new grant in the same cycle keeps out_valid=1 and loads the new word (back-to-back).
- While out_valid=1 and out_ready=0: out_data and out_ch are held stable and in_ready is all 0.
- RR pointer:
  - Updates only on an input transfer in mode=0: ptr <= (g==NUM_CH-1) ? 0 : g+1.
  - Unchanged in mode=1 and when there is no transfer.
- Mode and sel changes take effect in the same cycle's arbitration. They never alter a word already held in the output register.
- in_valid deasserting before a grant is legal; the channel simply loses arbitration.

Test Plan:
1. Reset with all in_valid=1, rst_n=0 for 2 cycles -> in_ready=0000, out_valid=0, out_data=0, out_ch=0 throughout. First grant after rst_n=1 is channel 0.
2. mode=0, all four channels valid with data 0x10,0x21,0x32,0x43, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 on consecutive cycles, out_data matching, starting 1 cycle after the first grant.
3. mode=0, only channels 1 and 3 valid -> grants alternate 1,3,1,3. Channel 3 grant followed by wrap back to 1. in_ready[0] and in_ready[2] are never 1.
4. Backpressure: word 0x55 from ch2 loaded, out_ready=0 for 5 cycles -> out_valid=1, out_data=0x55, out_ch=2 stable, in_ready=0000. out_ready=1 -> next grant loads in that same cycle with no bubble.
5. mode=1, sel=2, all valid -> only ch2 is granted each cycle. sel=3 with in_valid[3]=0 -> no grant, out_valid falls to 0 after the pending word drains. Run with NUM_CH=3, sel=3 -> never granted.
6. Reset mid-operation: rst_n=0 while out_valid=1 holding 0x43 -> next cycle out_valid=0, out_data=0. RR pointer back to 0, so the first post-reset grant is the lowest valid channel.
